// File: rtl/csv_tok_pkg.sv
// Shared types and constants for the CSV byte tokenizer.
// Widths in tok_beat_t match the default MAX_FIELDS/REC_W configuration.
package csv_tok_pkg;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   localparam int unsigned TOK_FIELD_W = 6;
   localparam int unsigned TOK_REC_W   = 16;

   typedef enum logic [2:0] {
      FIELD_START,
      UNQUOTED,
      QUOTED,
      QUOTE_SEEN,
      CR_SEEN,
      FLUSH
   } tok_state_e;

   typedef struct packed {
      logic [7:0]             data;
      logic                   empty;
      logic                   field_end;
      logic                   record_end;
      logic [TOK_FIELD_W-1:0] field_idx;
      logic [TOK_REC_W-1:0]   record_idx;
   } tok_beat_t;

endpackage

// File: rtl/csv_byte_tokenizer_if.sv
// Byte-in / tagged-beat-out handshake bundle of the CSV tokenizer.
interface csv_byte_tokenizer_if #(
   parameter int unsigned FIELD_W = 6,
   parameter int unsigned REC_W   = 16
);
   logic               s_valid;
   logic               s_ready;
   logic [7:0]         s_data;
   logic               s_last;
   logic               m_valid;
   logic               m_ready;
   logic [7:0]         m_data;
   logic               m_empty;
   logic               m_field_end;
   logic               m_record_end;
   logic [FIELD_W-1:0] m_field_idx;
   logic [REC_W-1:0]   m_record_idx;

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_empty, m_field_end, m_record_end,
             m_field_idx, m_record_idx
   );

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_data, m_empty, m_field_end, m_record_end,
             m_field_idx, m_record_idx
   );
endinterface

// File: rtl/csv_tok_out_reg.sv
// Single valid/ready output stage; a loaded beat is held until the sink takes it.
module csv_tok_out_reg
   import csv_tok_pkg::*;
#(
   parameter type beat_t = tok_beat_t
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load_i,
   input  logic  ready_i,
   input  beat_t beat_i,
   output logic  valid_o,
   output beat_t beat_o
);
   logic  valid_q;
   beat_t beat_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         beat_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         beat_q  <= beat_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign beat_o  = beat_q;
endmodule

// File: rtl/csv_byte_tokenizer.sv
// CSV byte-stream tokenizer: one field character per beat, field/record end tagged on the last beat.
// A character is held in the pending register until the next byte reveals whether it ends its field.
module csv_byte_tokenizer
   import csv_tok_pkg::*;
#(
   parameter logic [7:0]  DELIM      = 8'h2C,
   parameter logic [7:0]  QUOTE      = 8'h22,
   parameter int unsigned MAX_FIELDS = 64,
   parameter int unsigned REC_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   csv_byte_tokenizer_if.slave  bus,
   output logic                 err_quote,
   output logic                 err_overflow
);
   localparam int unsigned FIELD_W = $clog2(MAX_FIELDS);

   typedef struct packed {
      logic [7:0]         data;
      logic               empty;
      logic               field_end;
      logic               record_end;
      logic [FIELD_W-1:0] field_idx;
      logic [REC_W-1:0]   record_idx;
   } beat_t;

   tok_state_e         state_q, state_d, cur_st;
   logic               pend_valid_q, pend_valid_d;
   logic [7:0]         pend_data_q, pend_data_d;
   logic [FIELD_W-1:0] field_idx_q, field_idx_d;
   logic [REC_W-1:0]   record_idx_q, record_idx_d;
   logic               err_quote_q, err_quote_d;
   logic               err_ovf_q, err_ovf_d;
   logic               out_free, accept, load, m_valid;
   logic               do_char, do_term, term_rec, rec_done, is_rec, is_term;
   beat_t              beat_d, beat_q;

   assign out_free    = !m_valid || bus.m_ready;
   assign bus.s_ready = rst_n && out_free && (state_q != FLUSH);
   assign accept      = bus.s_valid && bus.s_ready;

   always_comb begin
      state_d      = state_q;
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      field_idx_d  = field_idx_q;
      record_idx_d = record_idx_q;
      err_quote_d  = err_quote_q;
      err_ovf_d    = err_ovf_q;
      load         = 1'b0;
      do_char      = 1'b0;
      do_term      = 1'b0;
      term_rec     = 1'b0;
      rec_done     = 1'b0;
      is_rec       = (bus.s_data == CR) || (bus.s_data == LF);
      is_term      = is_rec || (bus.s_data == DELIM);
      // A non-LF byte after CR starts a fresh field as if from FIELD_START.
      cur_st       = (state_q == CR_SEEN) ? FIELD_START : state_q;
      beat_d            = '0;
      beat_d.field_idx  = field_idx_q;
      beat_d.record_idx = record_idx_q;

      if (state_q == FLUSH) begin
         if (out_free) begin
            do_term  = 1'b1;
            term_rec = 1'b1;
            state_d  = FIELD_START;
         end
      end else if (accept) begin
         if (state_q == CR_SEEN && bus.s_data == LF) begin
            rec_done = 1'b1;
            state_d  = FIELD_START;
         end else begin
            case (cur_st)
               FIELD_START: begin
                  if (bus.s_data == QUOTE) state_d = QUOTED;
                  else if (is_term) begin
                     do_term  = 1'b1;
                     term_rec = is_rec;
                  end else begin
                     do_char = 1'b1;
                     state_d = UNQUOTED;
                  end
               end
               UNQUOTED: begin
                  if (is_term) begin
                     do_term  = 1'b1;
                     term_rec = is_rec;
                  end else begin
                     do_char = 1'b1;
                     if (bus.s_data == QUOTE) err_quote_d = 1'b1;
                  end
               end
               QUOTED: begin
                  if (bus.s_data == QUOTE) state_d = QUOTE_SEEN;
                  else do_char = 1'b1;
               end
               QUOTE_SEEN: begin
                  if (bus.s_data == QUOTE) begin
                     do_char = 1'b1;
                     state_d = QUOTED;
                  end else if (is_term) begin
                     do_term  = 1'b1;
                     term_rec = is_rec;
                  end else begin
                     do_char     = 1'b1;
                     err_quote_d = 1'b1;
                     state_d     = UNQUOTED;
                  end
               end
               default: ;
            endcase
            if (do_term) begin
               state_d  = (term_rec && bus.s_data == CR) ? CR_SEEN : FIELD_START;
               rec_done = term_rec;
            end
         end
         if (bus.s_last) begin
            if (rec_done) state_d = FIELD_START;
            else begin
               if (state_d == QUOTED) err_quote_d = 1'b1;
               state_d = FLUSH;
            end
         end
      end

      if (do_term) begin
         load              = 1'b1;
         beat_d.data       = pend_valid_q ? pend_data_q : '0;
         beat_d.empty      = !pend_valid_q;
         beat_d.field_end  = 1'b1;
         beat_d.record_end = term_rec;
         pend_valid_d      = 1'b0;
         pend_data_d       = '0;
         if (term_rec) begin
            field_idx_d  = '0;
            record_idx_d = record_idx_q + REC_W'(1);
         end else if (field_idx_q == FIELD_W'(MAX_FIELDS - 1)) begin
            err_ovf_d = 1'b1;
         end else begin
            field_idx_d = field_idx_q + FIELD_W'(1);
         end
      end else if (do_char) begin
         load         = pend_valid_q;
         beat_d.data  = pend_data_q;
         pend_valid_d = 1'b1;
         pend_data_d  = bus.s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FIELD_START;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         field_idx_q  <= '0;
         record_idx_q <= '0;
         err_quote_q  <= 1'b0;
         err_ovf_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
         field_idx_q  <= field_idx_d;
         record_idx_q <= record_idx_d;
         err_quote_q  <= err_quote_d;
         err_ovf_q    <= err_ovf_d;
      end
   end

   csv_tok_out_reg #(
      .beat_t (beat_t)
   ) u_out_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load),
      .ready_i (bus.m_ready),
      .beat_i  (beat_d),
      .valid_o (m_valid),
      .beat_o  (beat_q)
   );

   assign bus.m_valid      = m_valid;
   assign bus.m_data       = beat_q.data;
   assign bus.m_empty      = beat_q.empty;
   assign bus.m_field_end  = beat_q.field_end;
   assign bus.m_record_end = beat_q.record_end;
   assign bus.m_field_idx  = beat_q.field_idx;
   assign bus.m_record_idx = beat_q.record_idx;
   assign err_quote        = err_quote_q;
   assign err_overflow     = err_ovf_q;
endmodule

// File: doc/csv_byte_tokenizer.md
Name: csv_byte_tokenizer

Overview:
- Synthesizable front-end tokenizer that converts a raw CSV byte stream into tagged field characters.
- Sits directly upstream of the CSV record/field consumer.
- Resolves delimiters, quoting, escaped quotes and CR/LF/CRLF line endings.
- Emits one character per beat, with end-of-field and end-of-record tags attached to the last beat of each field.

Parameters:
- DELIM, 8'h2C, field delimiter byte
- QUOTE, 8'h22, quote byte
- MAX_FIELDS, 64, fields per record; FIELD_W = $clog2(MAX_FIELDS)
- REC_W, 16, record counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid&&s_ready
- s_data  in  8  input byte
- s_last  in  1  final byte of the stream
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_data  out  8  field character (0 when m_empty)
- m_empty  out  1  beat carries no character (empty field)
- m_field_end  out  1  last beat of field
- m_record_end  out  1  last beat of record
- m_field_idx  out  FIELD_W  field index within record
- m_record_idx  out  REC_W  record index, wraps modulo 2^REC_W
- err_quote  out  1  sticky: malformed quoting seen
- err_overflow  out  1  sticky: field count exceeded MAX_FIELDS

Behaviour:
- Reset, asynchronous:
  - All outputs 0; s_ready 0 while rst_n is low.
  - Pending register empty; state FIELD_START; counters 0.
- Output register:
  - Single register stage; beat held stable until m_ready.
  - s_ready = (!m_valid || m_ready) && state != FLUSH.
  - Each accepted byte produces at most one beat, registered one cycle after acceptance.
- Pending register (pend_valid, pend_data) holds the latest character, because field end is only known on the following byte.
- Character byte:
  - If pend_valid, emit pend as a plain beat.
  - The new byte becomes pend.
- Field terminator (DELIM outside quotes):
  - Emit pend with m_field_end=1, or an m_empty beat if no pend.
  - Clear pend; field_idx+1.
- Record terminator (CR or LF outside quotes):
  - Same as field terminator, plus m_record_end=1.
  - field_idx←0; record_idx+1.
  - CR enters CR_SEEN. In CR_SEEN, LF is swallowed (no beat); any other byte is processed as from FIELD_START.
- States:
  - FIELD_START:
    - QUOTE→QUOTED, no beat.
    - DELIM/CR/LF→terminator.
    - Else→char, then UNQUOTED.
  - UNQUOTED:
    - DELIM/CR/LF→terminator, then FIELD_START/CR_SEEN.
    - QUOTE→err_quote=1, treated as a character.
  - QUOTED: QUOTE→QUOTE_SEEN, no beat; every other byte, including DELIM/CR/LF, is a character.
  - QUOTE_SEEN:
    - QUOTE→literal quote character, then QUOTED.
    - DELIM/CR/LF→terminator.
    - Other→err_quote=1, byte is a character, then UNQUOTED.
  - CR_SEEN: as described under record terminator.
  - FLUSH: see s_last.
- Blank line: emits one m_empty beat with field_end and record_end.
- s_last accepted, byte processed normally:
  - If that byte was a record terminator, return to FIELD_START with no extra beat.
  - Otherwise enter FLUSH and emit one beat closing the open record: pend, or m_empty, with field_end=1 and record_end=1.
  - Then counters update and state returns to FIELD_START.
  - s_last inside QUOTED also sets err_quote.
- field_idx saturates at MAX_FIELDS-1; a further field_end sets err_overflow.
- Sticky errors clear only on reset.
- Reset mid-record discards pend and the output beat.

Decomposition:
- csv_tok_pkg holds:
  - state enum tok_state_e (FIELD_START, UNQUOTED, QUOTED, QUOTE_SEEN, CR_SEEN, FLUSH)
  - byte constants CR=8'h0D, LF=8'h0A
  - packed struct tok_beat_t {data, empty, field_end, record_end, field_idx, record_idx}
- One sub-module, csv_tok_out_reg: the valid/ready output register holding a tok_beat_t.

Test Plan:
- Bytes "a,bc\n" with m_ready=1 → beats a(fe,idx0), b(idx1), c(fe,re,idx1); record_idx 0; next record_idx 1.
- Bytes "\"x,\"\"y\"\"\",z\r\n" → beats x , " y "(fe,idx0), z(fe,re,idx1); CRLF yields exactly one record end; err_quote=0.
- Bytes ",,\n" → three m_empty beats: idx0 fe, idx1 fe, idx2 fe+re.
- Bytes "ab" with s_last on 'b' → a plain, b fe+re via FLUSH; s_ready=0 during FLUSH.
- Bytes "1,2\n" with m_ready toggled 1010… → identical beat sequence; m_* stable while m_valid&&!m_ready; no byte lost.
- MAX_FIELDS=4, 5 fields in one record → field_idx holds at 3, err_overflow=1; "a\"b," → err_quote=1, beats a, ", b(fe).
